// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - ordered per-channel reset release sequencer with soft re-run
// Optional ordered drain on soft request in RUN: RST_SEQ_CTRL_ORDERED_DRAIN_EN
module rst_seq_ctrl #(
  parameter int N_CH     = 4,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 4,
  parameter int CNT_W    = $clog2(((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC) + 1)
) (
  input  logic            i_clk,
  input  logic            i_sync_rst_n,
  input  logic            i_soft_rst_req,
  output logic [N_CH-1:0] o_ch_rst,
  output logic            o_busy,
  output logic            o_done
);

  localparam int IDX_W = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

`ifdef RST_SEQ_CTRL_ORDERED_DRAIN_EN
  typedef enum logic [1:0] {ST_HOLD, ST_STAGGER, ST_RUN, ST_DRAIN} state_t;
`else
  typedef enum logic [1:0] {ST_HOLD, ST_STAGGER, ST_RUN} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N_CH-1:0]  ch_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             restart;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    ch_nxt    = o_ch_rst;
    busy_nxt  = o_busy;
    done_nxt  = 1'b0;
    restart   = 1'b0;

    case (state)
      ST_HOLD: begin
        if (i_soft_rst_req) begin
          restart = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          ch_nxt[0] = 1'b0;
          cnt_nxt   = '0;
          idx_nxt   = IDX_W'(1);
          if (N_CH == 1) begin
            state_nxt = ST_RUN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_STAGGER;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_STAGGER: begin
        if (i_soft_rst_req) begin
          restart = 1'b1;
        end else if (cnt == GAP_LAST) begin
          for (int k = 0; k < N_CH; k++) begin
            if (IDX_W'(k) == idx) ch_nxt[k] = 1'b0;
          end
          cnt_nxt = '0;
          idx_nxt = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state_nxt = ST_RUN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (i_soft_rst_req) begin
`ifdef RST_SEQ_CTRL_ORDERED_DRAIN_EN
          // Highest channel goes back into reset first; lower ones follow at GAP spacing.
          ch_nxt[N_CH-1] = 1'b1;
          busy_nxt       = 1'b1;
          cnt_nxt        = '0;
          if (N_CH == 1) begin
            state_nxt = ST_HOLD;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_DRAIN;
            idx_nxt   = LAST_IDX;
          end
`else
          restart = 1'b1;
`endif
        end
      end

`ifdef RST_SEQ_CTRL_ORDERED_DRAIN_EN
      ST_DRAIN: begin
        // idx is the lowest channel already reasserted; soft requests are ignored here.
        if (cnt == GAP_LAST) begin
          for (int k = 0; k < N_CH; k++) begin
            if (IDX_W'(k) == idx - IDX_W'(1)) ch_nxt[k] = 1'b1;
          end
          cnt_nxt = '0;
          idx_nxt = idx - IDX_W'(1);
          if (idx == IDX_W'(1)) begin
            state_nxt = ST_HOLD;
            idx_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif

      default: begin
        restart = 1'b1;
      end
    endcase

    if (restart) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      ch_nxt    = '1;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state    <= ST_HOLD;
      cnt      <= '0;
      idx      <= '0;
      o_ch_rst <= '1;
      o_busy   <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      o_ch_rst <= ch_nxt;
      o_busy   <= busy_nxt;
      o_done   <= done_nxt;
    end
  end

endmodule
